// File: rtl/sram_burst_if.sv
// sram_burst_if
//   Host-side engine for an asynchronous SRAM whose data bus is twice the host word width.
//   A command (read or write, start address, bank) is accepted in IDLE and run as one or more
//   beats. Each beat is SETUP (address and chip/byte enables), STROBE (WE_N or OE_N low for
//   WAIT_STATES+1 cycles) and, for writes only, HOLD (WE_N high while data and address are
//   still driven). The last beat is followed by one RECOVER cycle with the bus fully idle.
//   BANK_SEL picks which half of the SRAM word is used: the lower LANES/2 byte lanes for 0,
//   the upper half for 1. Write words are replicated on both halves of SRAM_D.
//
//   Optional feature (build macro SRAM_BURST_EN):
//     defined   - a command runs BURST_LEN+1 beats at consecutive addresses, wrapping at the top
//                 of the address space; WDATA_REQ asks for the next write word.
//     undefined - BURST_LEN is ignored, every command is one beat, WDATA_REQ is tied low.
//
//   Ports
//     CLK_48MHZ, RESET          clock, asynchronous active-high reset
//     CMD_VALID/CMD_READY       command handshake (ready only in IDLE)
//     CMD_WRITE, ADDRESS_IN,
//     BANK_SEL, BURST_LEN       command fields, latched on acceptance
//     WDATA, WDATA_REQ          write word (first word latched with the command)
//     RDATA, RDATA_VALID        read word and one-cycle strobe
//     BUSY                      a command is in progress
//     SRAM_*                    SRAM pins, control signals active-low

module sram_burst_if #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BURST_W     = 4,
  localparam int unsigned LANES      = 2 * DATA_W / 8
) (
  input  logic                CLK_48MHZ,
  input  logic                RESET,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS_IN,
  input  logic                BANK_SEL,
  input  logic [BURST_W-1:0]  BURST_LEN,
  input  logic [DATA_W-1:0]   WDATA,
  output logic                WDATA_REQ,
  output logic [DATA_W-1:0]   RDATA,
  output logic                RDATA_VALID,
  output logic                BUSY,
  output logic [ADDR_W-1:0]   SRAM_A,
  inout  wire  [2*DATA_W-1:0] SRAM_D,
  output logic [LANES-1:0]    SRAM_BS_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N
);

  // Byte-lane enables (active low) for each bank.
  localparam logic [LANES-1:0] BsBank0 = {{(LANES/2){1'b1}}, {(LANES/2){1'b0}}};
  localparam logic [LANES-1:0] BsBank1 = {{(LANES/2){1'b0}}, {(LANES/2){1'b1}}};
  // Strobe counter value on the final strobe cycle; WAIT_STATES is limited to 0..15.
  localparam logic [3:0]       WsLast  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bank_q, bank_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

`ifdef SRAM_BURST_EN
  logic [BURST_W-1:0]  beats_q, beats_d;  // beats still to run after the current one
`else
  logic                unused_burst_len;
  assign unused_burst_len = ^BURST_LEN;
`endif

  logic                cmd_ready;
  logic                wdata_req;
  logic                drive_bus;
  logic                ce_n, we_n, oe_n;
  logic [LANES-1:0]    bs_n;
  logic [LANES-1:0]    lane_mask;
  logic [DATA_W-1:0]   rd_half;

  assign lane_mask = bank_q ? BsBank1 : BsBank0;
  assign rd_half   = bank_q ? SRAM_D[2*DATA_W-1:DATA_W] : SRAM_D[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
`ifdef SRAM_BURST_EN
    beats_d   = beats_q;
`endif
    cmd_ready = 1'b0;
    wdata_req = 1'b0;
    drive_bus = 1'b0;
    ce_n      = 1'b1;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    bs_n      = '1;

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (CMD_VALID) begin
          addr_d  = ADDRESS_IN;
          bank_d  = BANK_SEL;
          write_d = CMD_WRITE;
          if (CMD_WRITE) begin
            wdata_d = WDATA;
          end
`ifdef SRAM_BURST_EN
          beats_d = BURST_LEN;
`endif
          state_d = StSetup;
        end
      end

      StSetup: begin
        ce_n      = 1'b0;
        bs_n      = lane_mask;
        drive_bus = write_q;
        wait_d    = 4'd0;
        state_d   = StStrobe;
      end

      StStrobe: begin
        ce_n      = 1'b0;
        bs_n      = lane_mask;
        drive_bus = write_q;
        we_n      = ~write_q;
        oe_n      = write_q;
        if (wait_q == WsLast) begin
          if (write_q) begin
            state_d = StHold;
          end else begin
            // Capture on the closing edge of the last strobe cycle.
            rdata_d  = rd_half;
            rvalid_d = 1'b1;
`ifdef SRAM_BURST_EN
            if (beats_q != '0) begin
              addr_d  = addr_q + 1'b1;
              beats_d = beats_q - 1'b1;
              state_d = StSetup;
            end else
`endif
            state_d = StRecover;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      StHold: begin
        ce_n      = 1'b0;
        bs_n      = lane_mask;
        drive_bus = 1'b1;
`ifdef SRAM_BURST_EN
        if (beats_q != '0) begin
          // The next write word is taken at the end of this cycle.
          wdata_req = 1'b1;
          wdata_d   = WDATA;
          addr_d    = addr_q + 1'b1;
          beats_d   = beats_q - 1'b1;
          state_d   = StSetup;
        end else
`endif
        state_d = StRecover;
      end

      StRecover: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      bank_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_q   <= 4'd0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef SRAM_BURST_EN
      beats_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef SRAM_BURST_EN
      beats_q  <= beats_d;
`endif
    end
  end

  // State is already IDLE while RESET is high; ready is held low until release.
  assign CMD_READY   = cmd_ready & ~RESET;
  assign BUSY        = (state_q != StIdle);
  assign WDATA_REQ   = wdata_req;
  assign RDATA       = rdata_q;
  assign RDATA_VALID = rvalid_q;
  assign SRAM_A      = addr_q;
  assign SRAM_CE_N   = ce_n;
  assign SRAM_WE_N   = we_n;
  assign SRAM_OE_N   = oe_n;
  assign SRAM_BS_N   = bs_n;
  assign SRAM_D      = drive_bus ? {wdata_q, wdata_q} : {(2*DATA_W){1'bz}};

endmodule

// File: tb/tb_sram_burst_if.sv
// Testbench for sram_burst_if (ADDR_W=18, DATA_W=16, WAIT_STATES=1, BURST_W=4).
// For every command the expected per-cycle pin trace is built from the beat rules
// (setup, strobes, hold, recover) and compared cycle by cycle at the falling edge.
// An SRAM model drives a known address-derived word whenever OE_N and CE_N are low.

module tb_sram_burst_if;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned WS = 1;
  localparam int unsigned BW = 4;
`ifdef SRAM_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] address_in;
  logic          bank_sel;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] wdata;
  logic          wdata_req;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic [AW-1:0] sram_a;
  wire  [31:0]   sram_d;
  logic [3:0]    sram_bs_n;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic          sram_oe_n;

  logic [15:0]   salt_hi;
  logic [15:0]   salt_lo;
  logic          mem_drive;

  assign mem_drive = !sram_oe_n && !sram_ce_n;
  assign sram_d    = mem_drive ? {sram_a[15:0] ^ salt_hi, sram_a[15:0] ^ salt_lo} : 32'bz;

  always #5 clk = ~clk;

  sram_burst_if #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_STATES (WS),
    .BURST_W     (BW)
  ) dut (
    .CLK_48MHZ   (clk),
    .RESET       (rst),
    .CMD_VALID   (cmd_valid),
    .CMD_READY   (cmd_ready),
    .CMD_WRITE   (cmd_write),
    .ADDRESS_IN  (address_in),
    .BANK_SEL    (bank_sel),
    .BURST_LEN   (burst_len),
    .WDATA       (wdata),
    .WDATA_REQ   (wdata_req),
    .RDATA       (rdata),
    .RDATA_VALID (rdata_valid),
    .BUSY        (busy),
    .SRAM_A      (sram_a),
    .SRAM_D      (sram_d),
    .SRAM_BS_N   (sram_bs_n),
    .SRAM_CE_N   (sram_ce_n),
    .SRAM_WE_N   (sram_we_n),
    .SRAM_OE_N   (sram_oe_n)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        ce_n;
    logic        we_n;
    logic        oe_n;
    logic [3:0]  bs_n;
    logic [17:0] a;
    logic        achk;
    logic        dchk;
    logic [31:0] d;
    logic        rv;
    logic [15:0] rd;
    logic        wreq;
    logic [15:0] wnext;
  } cyc_t;

  cyc_t        sched[$];
  logic [15:0] words[16];
  logic [15:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected trace of one command, one entry per cycle after acceptance.
  task automatic build_sched(input logic wr, input logic [17:0] addr, input logic bank,
                             input logic [3:0] blen);
    int          beats;
    logic [17:0] a;
    logic        pend;
    logic [15:0] pval;
    logic [15:0] rd;
    logic [31:0] word;
    logic [3:0]  mask;
    cyc_t        r;
    beats = BurstEn ? int'(blen) + 1 : 1;
    mask  = bank ? 4'b0011 : 4'b1100;
    rd    = exp_rdata;
    pend  = 1'b0;
    pval  = '0;
    sched.delete();
    for (int b = 0; b < beats; b++) begin
      a = addr + 18'(b);
      r = '0;
      r.ce_n = 1'b0; r.we_n = 1'b1; r.oe_n = 1'b1; r.bs_n = mask; r.a = a; r.achk = 1'b1;
      r.dchk = 1'b1;
      r.d    = wr ? {words[b], words[b]} : 32'bz;
      r.rv   = pend;
      if (pend) rd = pval;
      r.rd   = rd;
      pend   = 1'b0;
      sched.push_back(r);
      for (int s = 0; s <= int'(WS); s++) begin
        r.we_n = !wr;
        r.oe_n = wr;
        r.dchk = wr;
        r.rv   = 1'b0;
        sched.push_back(r);
      end
      if (wr) begin
        r.we_n  = 1'b1;
        r.oe_n  = 1'b1;
        r.dchk  = 1'b1;
        r.wreq  = (b != beats - 1);
        r.wnext = (b + 1 < 16) ? words[b+1] : 16'h0;
        sched.push_back(r);
      end else begin
        word = {a[15:0] ^ salt_hi, a[15:0] ^ salt_lo};
        pend = 1'b1;
        pval = bank ? word[31:16] : word[15:0];
      end
    end
    r = '0;
    r.ce_n = 1'b1; r.we_n = 1'b1; r.oe_n = 1'b1; r.bs_n = 4'hF; r.dchk = 1'b1; r.d = 32'bz;
    r.rv   = pend;
    if (pend) rd = pval;
    r.rd   = rd;
    sched.push_back(r);
    exp_rdata = rd;
  endtask

  task automatic check_rec(input cyc_t e, input string t);
    chk({t, ".ce_n"}, 64'(sram_ce_n), 64'(e.ce_n));
    chk({t, ".we_n"}, 64'(sram_we_n), 64'(e.we_n));
    chk({t, ".oe_n"}, 64'(sram_oe_n), 64'(e.oe_n));
    chk({t, ".bs_n"}, 64'(sram_bs_n), 64'(e.bs_n));
    if (e.achk) chk({t, ".addr"}, 64'(sram_a), 64'(e.a));
    if (e.dchk) chk({t, ".sram_d"}, {32'h0, sram_d}, {32'h0, e.d});
    chk({t, ".rvalid"}, 64'(rdata_valid), 64'(e.rv));
    chk({t, ".rdata"}, 64'(rdata), 64'(e.rd));
    chk({t, ".wreq"}, 64'(wdata_req), 64'(e.wreq));
    chk({t, ".ready"}, 64'(cmd_ready), 64'h0);
    chk({t, ".busy"}, 64'(busy), 64'h1);
  endtask

  task automatic check_idle(input string t);
    chk({t, ".ready"}, 64'(cmd_ready), 64'h1);
    chk({t, ".busy"}, 64'(busy), 64'h0);
    chk({t, ".ce_n"}, 64'(sram_ce_n), 64'h1);
    chk({t, ".we_n"}, 64'(sram_we_n), 64'h1);
    chk({t, ".oe_n"}, 64'(sram_oe_n), 64'h1);
    chk({t, ".sram_d"}, {32'h0, sram_d}, {32'h0, 32'bz});
    chk({t, ".rvalid"}, 64'(rdata_valid), 64'h0);
    chk({t, ".rdata"}, 64'(rdata), 64'(exp_rdata));
    chk({t, ".wreq"}, 64'(wdata_req), 64'h0);
  endtask

  task automatic check_reset(input string t);
    chk({t, ".ce_n"}, 64'(sram_ce_n), 64'h1);
    chk({t, ".we_n"}, 64'(sram_we_n), 64'h1);
    chk({t, ".oe_n"}, 64'(sram_oe_n), 64'h1);
    chk({t, ".bs_n"}, 64'(sram_bs_n), 64'hF);
    chk({t, ".addr"}, 64'(sram_a), 64'h0);
    chk({t, ".sram_d"}, {32'h0, sram_d}, {32'h0, 32'bz});
    chk({t, ".rdata"}, 64'(rdata), 64'h0);
    chk({t, ".rvalid"}, 64'(rdata_valid), 64'h0);
    chk({t, ".wreq"}, 64'(wdata_req), 64'h0);
    chk({t, ".busy"}, 64'(busy), 64'h0);
    chk({t, ".ready"}, 64'(cmd_ready), 64'h0);
  endtask

  // Entered and left just after a rising edge with the DUT idle. rst_at >= 0 asserts RESET
  // in the middle of that trace cycle and checks the abort.
  task automatic run_cmd(input string tag, input logic wr, input logic [17:0] addr,
                         input logic bank, input logic [3:0] blen, input int rst_at);
    bit aborted;
    aborted = 1'b0;
    build_sched(wr, addr, bank, blen);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    address_in = addr;
    bank_sel   = bank;
    burst_len  = blen;
    wdata      = words[0];
    @(negedge clk);
    // exp_rdata already holds this command's final value; idle RDATA still shows the old one.
    chk({tag, ".pre.ready"}, 64'(cmd_ready), 64'h1);
    chk({tag, ".pre.busy"}, 64'(busy), 64'h0);
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      #1;
      // Command-side noise: must be ignored while a command runs.
      cmd_valid  = 1'($urandom);
      cmd_write  = 1'($urandom);
      address_in = 18'($urandom);
      bank_sel   = 1'($urandom);
      burst_len  = 4'($urandom);
      wdata      = sched[i].wreq ? sched[i].wnext : 16'($urandom);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset($sformatf("%s.rst_c%0d", tag, i));
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      check_rec(sched[i], $sformatf("%s.c%0d", tag, i));
    end
    if (aborted) begin
      exp_rdata = '0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_reset({tag, ".rst_hold"});
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_idle($sformatf("%s.post_rst%0d", tag, k));
        @(posedge clk);
        #1;
      end
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    logic        wr;
    logic [17:0] addr;
    int          rst_idx;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    address_in = '0;
    bank_sel   = 1'b0;
    burst_len  = '0;
    wdata      = '0;
    salt_hi    = 16'h5A5A;
    salt_lo    = 16'hC3C3;
    exp_rdata  = '0;
    for (int k = 0; k < 16; k++) words[k] = 16'($urandom);

    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk);
    #1;

    // Single read, bank 0: lower half of the SRAM word is 0xBEEF at address 0x00010.
    salt_lo = 16'hBEEF ^ 16'h0010;
    salt_hi = 16'h1357;
    run_cmd("rd_beef", 1'b0, 18'h00010, 1'b0, 4'd0, -1);
    chk("rd_beef.final", 64'(rdata), 64'hBEEF);

    // Single write at the top address, bank 1.
    words[0] = 16'h1234;
    run_cmd("wr_top", 1'b1, 18'h3FFFF, 1'b1, 4'd0, -1);
    @(negedge clk);
    check_idle("wr_top.idle");
    @(posedge clk);
    #1;

    // Four-beat write crossing the address wrap.
    words[0] = 16'hA1A1; words[1] = 16'hB2B2; words[2] = 16'hC3C3; words[3] = 16'hD4D4;
    run_cmd("wr_burst", 1'b1, 18'h3FFFE, 1'b0, 4'd3, -1);

    // Three-beat read, bank 1, crossing the wrap.
    salt_hi = 16'($urandom);
    salt_lo = 16'($urandom);
    run_cmd("rd_burst", 1'b0, 18'h3FFFF, 1'b1, 4'd2, -1);

    for (int n = 0; n < 20; n++) begin
      salt_hi = 16'($urandom);
      salt_lo = 16'($urandom);
      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      wr   = 1'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? 18'h3FFFC + 18'($urandom_range(0, 3))
                                          : 18'($urandom);
      run_cmd($sformatf("rnd%0d", n), wr, addr, 1'($urandom), 4'($urandom_range(0, 3)), -1);
    end

    // Reset during a strobe: second beat's strobe with bursts, last strobe otherwise.
    rst_idx = BurstEn ? (1 + int'(WS) + 1 + 1) : (1 + int'(WS));
    salt_hi = 16'($urandom);
    salt_lo = 16'($urandom);
    run_cmd("rst_mid", 1'b0, 18'h01000, 1'b0, 4'd2, rst_idx);

    // Normal operation after the abort.
    run_cmd("rd_after", 1'b0, 18'h00123, 1'b1, 4'd1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_burst_if.md
SRAM_BURST_IF -- requirements
Module: sram_burst_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, host word width; SRAM bus is 2*DATA_W, byte lanes LANES=2*DATA_W/8.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, extra strobe cycles per access.
REQ-004 SHALL have parameter BURST_W, default 4, width of BURST_LEN.
REQ-005 SHALL have CLK_48MHZ  in  1  sole clock, all state changes on rising edge.
REQ-006 SHALL have RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have CMD_VALID  in  1  command request; CMD_READY  out  1  accept-ready.
REQ-008 SHALL have CMD_WRITE  in  1  1=write, 0=read; ADDRESS_IN  in  ADDR_W  start address; BANK_SEL  in  1  0=lower half/lanes, 1=upper.
REQ-009 SHALL have BURST_LEN  in  BURST_W  beats minus one.
REQ-010 SHALL have WDATA  in  DATA_W  write word; WDATA_REQ  out  1  next write word consumed this cycle.
REQ-011 SHALL have RDATA  out  DATA_W  read word; RDATA_VALID  out  1  one-cycle read-word strobe; BUSY  out  1  command in progress.
REQ-012 SHALL have SRAM_A  out  ADDR_W; SRAM_D  inout  2*DATA_W; SRAM_BS_N  out  LANES; SRAM_CE_N, SRAM_WE_N, SRAM_OE_N  out  1 each, all active-low.

Function
REQ-013 SHALL implement states IDLE, SETUP, STROBE, HOLD, RECOVER.
REQ-014 IDLE: CMD_READY=1, BUSY=0; CMD_VALID&CMD_READY at an edge latches ADDRESS_IN, BANK_SEL, CMD_WRITE, BURST_LEN, WDATA (write) and moves to SETUP.
REQ-015 CMD_READY SHALL be 0 outside IDLE; CMD_VALID outside IDLE SHALL be ignored.
REQ-016 SETUP (1 cycle): SRAM_A=address, SRAM_CE_N=0, lower LANES/2 of SRAM_BS_N low if bank 0 else upper LANES/2 low, others high; write drives SRAM_D with the word replicated on both halves.
REQ-017 STROBE: SRAM_WE_N=0 (write) or SRAM_OE_N=0 (read) for exactly WAIT_STATES+1 cycles.
REQ-018 Read: selected SRAM_D half SHALL be captured into RDATA at the last STROBE edge; RDATA_VALID high for the following cycle.
REQ-019 Write: HOLD (1 cycle) SHALL deassert SRAM_WE_N while still driving SRAM_D and address.
REQ-020 Beats remaining: address increments by 1, wrapping 2^ADDR_W-1 -> 0, next state SETUP; read beat period WAIT_STATES+2 cycles, write beat WAIT_STATES+3.
REQ-021 WDATA_REQ SHALL be high during HOLD of every write beat except the last; WDATA is sampled at the end of that cycle.
REQ-022 Last beat: RECOVER (1 cycle) with CE_N, WE_N, OE_N, all BS_N high and SRAM_D high-Z, then IDLE.
REQ-023 SRAM_D SHALL be high-Z in every state except write SETUP/STROBE/HOLD; WE_N and OE_N SHALL never both be low.
REQ-024 Single read: RDATA_VALID in the cycle after edge WAIT_STATES+2 from acceptance; CMD_READY returns at edge WAIT_STATES+3.

Reset
REQ-025 RESET high SHALL immediately force IDLE, SRAM_CE_N/WE_N/OE_N=1, SRAM_BS_N all 1, SRAM_A=0, SRAM_D high-Z, RDATA=0, RDATA_VALID=0, WDATA_REQ=0, BUSY=0, CMD_READY=0 while RESET high.
REQ-026 Reset mid-burst SHALL abort without further strobes or RDATA_VALID; CMD_READY=1 on first edge after release.

Configuration
REQ-027 Macro SRAM_BURST_EN defined: multi-beat bursts per REQ-020/021.
REQ-028 SRAM_BURST_EN undefined: BURST_LEN ignored, every command one beat, WDATA_REQ tied 0, no address incrementer.

Verification
REQ-029 WAIT_STATES=1, read 0x00010 bank 0, lower SRAM_D=0xBEEF -> RDATA=0xBEEF, RDATA_VALID 4th cycle after accept, OE_N low 2 cycles, BS_N=4'b1100.
REQ-030 Write 0x3FFFF bank 1 WDATA=0x1234 -> SRAM_D=0x12341234, WE_N low 2 cycles, BS_N=4'b0011, bus Z after HOLD.
REQ-031 SRAM_BURST_EN, write BURST_LEN=3 from 0x3FFFE -> addresses 0x3FFFE,0x3FFFF,0x00000,0x00001, WDATA_REQ three pulses.
REQ-032 Read burst BURST_LEN=2, WAIT_STATES=0 -> three RDATA_VALID pulses 2 cycles apart, CMD_VALID during burst ignored.
REQ-033 RESET asserted during 2nd STROBE of a burst -> all strobes high, SRAM_D Z same cycle, no RDATA_VALID, CMD_READY=1 after release.
